// File: rtl/icache_tag_ctrl_if.sv
// Signal bundle between the icache tag controller and its environment:
// fetch handshake, memory line port, flush control, tag/valid RAM port and perf counters.
interface icache_tag_ctrl_if #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned TAG_W = 23,
    parameter int unsigned CNT_W = 16
);
    logic             req_valid;
    logic [31:0]      req_addr;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_miss;
    logic             mem_req_valid;
    logic [31:0]      mem_req_addr;
    logic             mem_req_ready;
    logic             mem_fill_done;
    logic             flush;
    logic             flush_busy;
    logic [IDX_W-1:0] tag_index;
    logic             tag_wr;
    logic [TAG_W-1:0] tag_wr_data;
    logic [TAG_W-1:0] tag_rd_data;
    logic             val_wr;
    logic             val_wr_data;
    logic             val_rd;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        input  req_valid, req_addr, mem_req_ready, mem_fill_done, flush, tag_rd_data, val_rd,
        output req_ready, resp_valid, resp_miss, mem_req_valid, mem_req_addr, flush_busy,
               tag_index, tag_wr, tag_wr_data, val_wr, val_wr_data, hit_count, miss_count
    );

    modport slave (
        output req_valid, req_addr, mem_req_ready, mem_fill_done, flush, tag_rd_data, val_rd,
        input  req_ready, resp_valid, resp_miss, mem_req_valid, mem_req_addr, flush_busy,
               tag_index, tag_wr, tag_wr_data, val_wr, val_wr_data, hit_count, miss_count
    );
endinterface

// File: rtl/icache_tag_ctrl.sv
// Icache tag lookup/fill controller: hit/miss against itagRAM/ivalidRAM, line fill on miss,
// and a full valid-bit sweep on flush.
module icache_tag_ctrl #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned TAG_W = 23,
    parameter int unsigned OFF_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    icache_tag_ctrl_if.master bus
);
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        StIdle, StLookup, StMissReq, StMissWait, StFill, StFlush
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:OFF_W]   line_q, line_d;
    logic                    replay_q, replay_d;
    logic                    flush_pending_q, flush_pending_d;
    logic [IDX_W-1:0]        sweep_q, sweep_d;
    logic [CNT_W-1:0]        hit_count_q, miss_count_q;
    logic                    hit_inc, miss_inc;
    logic                    hit;
    logic [TAG_W-1:0]        line_tag;
    logic [IDX_W-1:0]        line_idx;

    assign line_tag = line_q[ADDR_W-1 -: TAG_W];
    assign line_idx = line_q[OFF_W +: IDX_W];
    assign hit      = bus.val_rd & (bus.tag_rd_data == line_tag);

    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        replay_d        = replay_q;
        flush_pending_d = flush_pending_q;
        sweep_d         = sweep_q;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.resp_miss     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.tag_index     = '0;
        bus.tag_wr        = 1'b0;
        bus.tag_wr_data   = '0;
        bus.val_wr        = 1'b0;
        bus.val_wr_data   = 1'b0;

        // A flush arriving mid-miss is deferred until the miss has completed.
        if (bus.flush && state_q != StIdle && state_q != StFlush) begin
            flush_pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.flush || flush_pending_q) begin
                    flush_pending_d = 1'b0;
                    sweep_d         = '0;
                    state_d         = StFlush;
                end else if (bus.req_valid) begin
                    line_d  = bus.req_addr[ADDR_W-1:OFF_W];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                bus.tag_index = line_idx;
                if (hit) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_miss  = replay_q;
                    hit_inc        = ~replay_q;
                    replay_d       = 1'b0;
                    state_d        = StIdle;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = StMissReq;
                end
            end
            StMissReq: begin
                bus.tag_index     = line_idx;
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = StMissWait;
            end
            StMissWait: begin
                bus.tag_index = line_idx;
                if (bus.mem_fill_done) state_d = StFill;
            end
            StFill: begin
                bus.tag_index   = line_idx;
                bus.tag_wr      = 1'b1;
                bus.tag_wr_data = line_tag;
                bus.val_wr      = 1'b1;
                bus.val_wr_data = 1'b1;
                replay_d        = 1'b1;
                state_d         = StLookup;
            end
            StFlush: begin
                bus.tag_index = sweep_q;
                bus.val_wr    = 1'b1;
                sweep_d       = sweep_q + IDX_W'(1);
                if (sweep_q == '1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_req_addr = {line_q, {OFF_W{1'b0}}};
    assign bus.req_ready    = ~reset & (state_q == StIdle) & ~flush_pending_q & ~bus.flush;
    assign bus.flush_busy   = (state_q == StFlush) | flush_pending_q;
    assign bus.hit_count    = hit_count_q;
    assign bus.miss_count   = miss_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            line_q          <= '0;
            replay_q        <= 1'b0;
            flush_pending_q <= 1'b0;
            sweep_q         <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            line_q          <= line_d;
            replay_q        <= replay_d;
            flush_pending_q <= flush_pending_d;
            sweep_q         <= sweep_d;
            if (hit_inc && hit_count_q != '1) hit_count_q <= hit_count_q + CNT_W'(1);
            if (miss_inc && miss_count_q != '1) miss_count_q <= miss_count_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with behavioural tag/valid RAMs and an inline memory port.
module tb_icache_tag_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icache_tag_ctrl_if #(.IDX_W(5), .TAG_W(23), .CNT_W(16)) bus ();

    icache_tag_ctrl #(.IDX_W(5), .TAG_W(23), .OFF_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural RAMs: combinational read, write on the clock edge.
    logic [22:0] tag_mem [32];
    logic        val_mem [32];
    assign bus.tag_rd_data = tag_mem[bus.tag_index];
    assign bus.val_rd      = val_mem[bus.tag_index];
    always @(posedge clk) begin
        if (bus.tag_wr) tag_mem[bus.tag_index] <= bus.tag_wr_data;
        if (bus.val_wr) val_mem[bus.tag_index] <= bus.val_wr_data;
    end

    // Counts valid-clear writes and checks they walk indices 0..31 in order.
    int sweep_writes  = 0;
    int sweep_idx_err = 0;
    always @(negedge clk) begin
        if (bus.val_wr && !bus.val_wr_data) begin
            if (32'(bus.tag_index) != 32'(sweep_writes % 32)) sweep_idx_err++;
            sweep_writes++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one lookup from IDLE and services the memory port until the response.
    // lat counts edges from the accepting edge to the response cycle (1 = hit).
    task automatic run_lookup(input logic [31:0] addr, input int ready_dly, input bit flush_in_wait,
                              output int lat, output logic miss, output int nreq,
                              output logic [31:0] maddr, output int nvalid,
                              output logic stable, output logic busy);
        int  wait_cyc;
        bit  in_wait;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        #1;
        chk("req_ready_at_accept", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        lat = 1; nreq = 0; nvalid = 0; maddr = '0; stable = 1'b1; miss = 1'b0; busy = 1'b0;
        in_wait = 1'b0; wait_cyc = 0;
        while (lat < 100) begin
            bus.mem_req_ready = 1'b0;
            bus.mem_fill_done = 1'b0;
            bus.flush         = 1'b0;
            if (in_wait) begin
                wait_cyc++;
                if (flush_in_wait && wait_cyc == 1) bus.flush = 1'b1;
                if (wait_cyc == 3) begin
                    bus.mem_fill_done = 1'b1;
                    in_wait = 1'b0;
                end
            end
            #1;
            if (bus.resp_valid) break;
            if (bus.mem_req_valid) begin
                if (nvalid == 0) maddr = bus.mem_req_addr;
                else if (bus.mem_req_addr !== maddr) stable = 1'b0;
                if (nvalid >= ready_dly) begin
                    bus.mem_req_ready = 1'b1;
                    nreq++;
                    in_wait = 1'b1;
                end
                nvalid++;
            end
            tick();
            lat++;
        end
        chk("lookup_completes", 32'(lat < 100), 32'd1);
        miss = bus.resp_miss;
        busy = bus.flush_busy;
        bus.mem_req_ready = 1'b0;
        bus.mem_fill_done = 1'b0;
        bus.flush         = 1'b0;
        tick();
    endtask

    // Entered with the sweep in progress or pending; runs until flush_busy drops.
    task automatic sweep_check(input int exp_cycles);
        int w0, c, rdy, resp;
        w0 = sweep_writes; c = 0; rdy = 0; resp = 0;
        chk("flush_busy_start", 32'(bus.flush_busy), 32'd1);
        while (bus.flush_busy && c < 100) begin
            if (bus.req_ready) rdy++;
            if (bus.resp_valid) resp++;
            tick();
            c++;
        end
        chk("sweep_busy_cycles", 32'(c), 32'(exp_cycles));
        chk("sweep_write_count", 32'(sweep_writes - w0), 32'd32);
        chk("sweep_index_order", 32'(sweep_idx_err), 32'd0);
        chk("req_ready_during_sweep", 32'(rdy), 32'd0);
        chk("resp_during_sweep", 32'(resp), 32'd0);
        chk("req_ready_after_sweep", 32'(bus.req_ready), 32'd1);
    endtask

    int          lat, nreq, nvalid;
    logic        miss, stable, busy;
    logic [31:0] maddr;

    initial begin
        for (int i = 0; i < 32; i++) begin
            tag_mem[i] = '0;
            val_mem[i] = 1'b0;
        end
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.mem_req_ready = 1'b0;
        bus.mem_fill_done = 1'b0; bus.flush = 1'b0;

        // 1: reset for two cycles
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
        chk("rst_flush_busy", 32'(bus.flush_busy), 32'd0);
        chk("rst_wr_enables", 32'({bus.tag_wr, bus.val_wr}), 32'd0);
        chk("rst_tag_index", 32'(bus.tag_index), 32'd0);
        chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
        chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);

        // 2: cold miss at 0x1AC0 -> index 12, tag addr[31:9] = 0xD
        run_lookup(32'h0000_1AC0, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("cold_latency", 32'(lat), 32'd7);
        chk("cold_resp_miss", 32'(miss), 32'd1);
        chk("cold_mem_reqs", 32'(nreq), 32'd1);
        chk("cold_mem_addr", maddr, 32'h0000_1AC0);
        chk("cold_tag_written", 32'(tag_mem[12]), 32'h0D);
        chk("cold_valid_written", 32'(val_mem[12]), 32'd1);
        chk("cold_miss_count", 32'(bus.miss_count), 32'd1);
        chk("cold_hit_count", 32'(bus.hit_count), 32'd0);

        // 3: same address hits, response in the cycle after accept
        run_lookup(32'h0000_1AC0, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("hit_latency", 32'(lat), 32'd1);
        chk("hit_resp_miss", 32'(miss), 32'd0);
        chk("hit_no_mem_req", 32'(nvalid), 32'd0);
        chk("hit_count_1", 32'(bus.hit_count), 32'd1);
        chk("hit_miss_count", 32'(bus.miss_count), 32'd1);

        // 4: same index, different tag (0x15) evicts; original line then misses again
        run_lookup(32'h0000_2AC0, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("conflict_resp_miss", 32'(miss), 32'd1);
        chk("conflict_mem_addr", maddr, 32'h0000_2AC0);
        chk("conflict_tag_written", 32'(tag_mem[12]), 32'h15);
        run_lookup(32'h0000_1AC0, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("refetch_resp_miss", 32'(miss), 32'd1);
        chk("refetch_mem_addr", maddr, 32'h0000_1AC0);
        chk("refetch_miss_count", 32'(bus.miss_count), 32'd3);

        // 5: flush together with a request; flush wins, request is not taken
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0000_1AC0;
        #1;
        chk("req_ready_with_flush", 32'(bus.req_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        sweep_check(32);
        chk("flush_cleared_valid", 32'(val_mem[12]), 32'd0);
        run_lookup(32'h0000_1AC0, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("post_flush_miss", 32'(miss), 32'd1);
        chk("post_flush_miss_count", 32'(bus.miss_count), 32'd4);
        chk("post_flush_hit_count", 32'(bus.hit_count), 32'd1);

        // 6: slow memory accept plus flush during MISS_WAIT; miss completes, then sweep
        run_lookup(32'h0000_5AC4, 10, 1'b1, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("slow_mem_valid_cycles", 32'(nvalid), 32'd11);
        chk("slow_mem_addr_stable", 32'(stable), 32'd1);
        chk("slow_mem_addr", maddr, 32'h0000_5AC0);
        chk("slow_resp_miss", 32'(miss), 32'd1);
        chk("flush_pending_at_resp", 32'(busy), 32'd1);
        chk("slow_tag_written", 32'(tag_mem[12]), 32'h2D);
        chk("pending_blocks_ready", 32'(bus.req_ready), 32'd0);
        sweep_check(33);
        run_lookup(32'h0000_5AC4, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("after_sweep_miss", 32'(miss), 32'd1);
        run_lookup(32'h0000_5AC8, 0, 1'b0, lat, miss, nreq, maddr, nvalid, stable, busy);
        chk("same_line_hit", 32'(miss), 32'd0);
        chk("final_hit_count", 32'(bus.hit_count), 32'd2);
        chk("final_miss_count", 32'(bus.miss_count), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
